// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the RV32I execute stage.
// Contents: datapath widths, ALU operation codes, forwarding-select codes
// and writeback-select codes used by execute_cycle and its ALU.
package execute_cycle_pkg;

  localparam int EX_XLEN = 32;
  localparam int EX_REGW = 5;

  // ALU operation encodings carried on ALUControlE
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Forwarding source selects from the hazard unit; 2'b11 falls back to the register file
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Writeback result selects
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   SrcA, SrcB  in  XLEN  operands
//   ALUControl  in  3     operation select (ALU_ADD..ALU_SRL)
//   Result      out XLEN  operation result (add/sub wrap, SLT gives 1/0)
//   Zero        out 1     Result equals zero
module alu
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = EX_XLEN
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic [4:0] shamt_s;

  assign shamt_s = SrcB[4:0];

  // Operation select; SLT compares as signed two's-complement values
  always_comb begin
    Result = {XLEN{1'b0}};
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_XOR: Result = SrcA ^ SrcB;
      ALU_SLT: begin
        if ($signed(SrcA) < $signed(SrcB)) begin
          Result = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
          Result = {XLEN{1'b0}};
        end
      end
      ALU_SLL: Result = SrcA << shamt_s;
      ALU_SRL: Result = SrcA >> shamt_s;
      default: Result = {XLEN{1'b0}};
    endcase
  end

  assign Zero = (Result == {XLEN{1'b0}});

endmodule

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline.
// Selects forwarded operands, runs the ALU, resolves beq/jal and the branch
// target, and holds the EX/MEM pipeline register feeding the MEM stage.
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   *E control/data inputs    from the ID/EX register
//   ForwardA_E, ForwardB_E    forwarding selects from the hazard unit
//   ResultW                   WB-stage result (forwarding source)
//   PCSrcE, PCTargetE         combinational branch/jump redirect to fetch
//   *M outputs                registered EX/MEM pipeline register
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = EX_XLEN,
  parameter int REGW = EX_REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a_s;
  logic [XLEN-1:0] fwd_b_s;
  logic [XLEN-1:0] src_b_s;
  logic [XLEN-1:0] alu_result_s;
  logic            zero_s;

  // Operand A forwarding: the MEM-stage source is our own registered ALU result
  always_comb begin
    src_a_s = RD1_E;
    case (ForwardA_E)
      FWD_WB:  src_a_s = ResultW;
      FWD_MEM: src_a_s = ALU_ResultM;
      default: src_a_s = RD1_E;
    endcase
  end

  // Operand B forwarding; this value is also the store data, never the immediate
  always_comb begin
    fwd_b_s = RD2_E;
    case (ForwardB_E)
      FWD_WB:  fwd_b_s = ResultW;
      FWD_MEM: fwd_b_s = ALU_ResultM;
      default: fwd_b_s = RD2_E;
    endcase
  end

  // Second ALU operand: immediate or forwarded rs2
  always_comb begin
    src_b_s = fwd_b_s;
    if (ALUSrcE) begin
      src_b_s = Imm_Ext_E;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a_s),
    .SrcB       (src_b_s),
    .ALUControl (ALUControlE),
    .Result     (alu_result_s),
    .Zero       (zero_s)
  );

  // Redirect stays combinational even during reset; fetch masks it
  assign PCSrcE    = (BranchE & zero_s) | JumpE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM pipeline register; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      RD_M        <= {REGW{1'b0}};
      PCPlus4M    <= {XLEN{1'b0}};
      WriteDataM  <= {XLEN{1'b0}};
      ALU_ResultM <= {XLEN{1'b0}};
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b_s;
      ALU_ResultM <= alu_result_s;
    end
  end

endmodule
